// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the I-cache/D-cache main-memory arbiter.
// Used by cache_mem_arbiter and arb_burst_ctr.
package cache_mem_arbiter_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int CNT_W       = 4;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IC_FILL  = 2'd1,
        ST_DC_FILL  = 2'd2,
        ST_DC_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_burst_ctr.sv
// Burst word counter: clear, increment enable, done flag at BLOCK_WORDS.
// Counts issued reads and returned read data of one cache block fill.
module arb_burst_ctr
    import cache_mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == CNT_W'(BLOCK_WORDS));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing pipelined main memory between I-cache and D-cache.
// Optional ARB_PERF_CNT_EN adds saturating per-requester wait-cycle counters.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_grant,
    output logic              ic_wait,
    output logic              ic_data_valid,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_grant,
    output logic              dc_wait,
    output logic              dc_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              memory_data_valid
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       ic_wait_cycles,
    output logic [15:0]       dc_wait_cycles
`endif
);

    arb_state_e        state_q, state_d;
    owner_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic             cnt_clr;
    logic             issue_inc, ret_inc;
    logic [CNT_W-1:0] issue_cnt, ret_cnt;
    logic             issue_done, ret_done;

    arb_burst_ctr u_issue_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (issue_inc),
        .cnt  (issue_cnt),
        .done (issue_done)
    );

    arb_burst_ctr u_ret_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (ret_inc),
        .cnt  (ret_cnt),
        .done (ret_done)
    );

    assign ic_grant = (state_q == ST_IC_FILL);
    assign dc_grant = (state_q == ST_DC_FILL) || (state_q == ST_DC_WRITE);

    // Requests may still be high during reset; keep every output at 0 then.
    assign ic_wait = ic_req && !ic_grant && !rst;
    assign dc_wait = dc_req && !dc_grant && !rst;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_clr       = 1'b0;
        issue_inc     = 1'b0;
        ret_inc       = 1'b0;
        mem_enable    = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        ic_data_valid = 1'b0;
        dc_data_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                // On contention the requester that did not go last wins.
                if (dc_req && (!ic_req || last_q == OWN_IC)) begin
                    addr_d  = dc_addr;
                    wdata_d = dc_wdata;
                    state_d = dc_we ? ST_DC_WRITE : ST_DC_FILL;
                end else if (ic_req) begin
                    addr_d  = ic_addr;
                    state_d = ST_IC_FILL;
                end
            end
            ST_IC_FILL, ST_DC_FILL: begin
                issue_inc  = !issue_done;
                mem_enable = !issue_done;
                if (!issue_done) begin
                    mem_addr = (addr_q & BLOCK_MASK)
                             | ADDR_W'({issue_cnt, 1'b0});
                end
                ret_inc       = memory_data_valid && !ret_done;
                ic_data_valid = memory_data_valid && (state_q == ST_IC_FILL);
                dc_data_valid = memory_data_valid && (state_q == ST_DC_FILL);
                if (memory_data_valid
                    && ret_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                    state_d = ST_IDLE;
                    last_d  = (state_q == ST_IC_FILL) ? OWN_IC : OWN_DC;
                    cnt_clr = 1'b1;
                end
            end
            ST_DC_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                state_d    = ST_IDLE;
                last_d     = OWN_DC;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= OWN_IC;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] ic_wcnt_q, ic_wcnt_d;
    logic [15:0] dc_wcnt_q, dc_wcnt_d;

    always_comb begin
        ic_wcnt_d = ic_wcnt_q;
        dc_wcnt_d = dc_wcnt_q;
        if (ic_wait && ic_wcnt_q != 16'hFFFF) ic_wcnt_d = ic_wcnt_q + 16'd1;
        if (dc_wait && dc_wcnt_q != 16'hFFFF) dc_wcnt_d = dc_wcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_wcnt_q <= '0;
            dc_wcnt_q <= '0;
        end else begin
            ic_wcnt_q <= ic_wcnt_d;
            dc_wcnt_q <= dc_wcnt_d;
        end
    end

    assign ic_wait_cycles = ic_wcnt_q;
    assign dc_wait_cycles = dc_wcnt_q;
`endif

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single pipelined main memory between the I-cache fill FSM and the D-cache (fill FSM plus write-through stores).
- Grants one requester at a time. For a fill it issues 8 sequential word reads; for a store it issues 1 write.
- Routes memory_data_valid back to the owner.
- Its per-requester wait outputs are the stall and arbitration inputs of the cache fill FSMs.

Parameters:
- MEM_LAT, 4: cycles from mem_enable (read) to the matching mem_data_valid.
- BLOCK_WORDS, 8: 16-bit words per cache block; 2-byte words, so 16 bytes per block.
- ADDR_W, 16: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req  in  1  I-cache fill request; held until ic_grant.
- ic_addr  in  16  I-cache miss address.
- ic_grant  out  1  I-cache owns memory.
- ic_wait  out  1  ic_req high and ic_grant low.
- ic_data_valid  out  1  memory_data_valid routed to the I-cache.
- dc_req  in  1  D-cache request; held until dc_grant.
- dc_we  in  1  qualifies dc_req: 1 means single-word store, 0 means block fill.
- dc_addr  in  16  D-cache miss or store address.
- dc_wdata  in  16  store data.
- dc_grant  out  1  D-cache owns memory.
- dc_wait  out  1  dc_req high and dc_grant low.
- dc_data_valid  out  1  memory_data_valid routed to the D-cache.
- mem_enable  out  1  memory operation this cycle.
- mem_wr  out  1  write when mem_enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- memory_data_valid  in  1  read data returning.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; issue_cnt and ret_cnt are 0; last_owner is IC.
  - All outputs are 0.
  - memory_data_valid still in flight after reset is ignored, because it is not routed while in IDLE.
- States are IDLE, IC_FILL, DC_FILL and DC_WRITE.
- IDLE decision:
  - Samples requests each cycle; the chosen state and grant register at the next edge.
  - If only one requester is active, it wins.
  - If both are active, the requester other than last_owner wins (round-robin). After reset the D-cache wins first.
  - dc_we selects DC_WRITE versus DC_FILL.
  - The address is captured at grant: base = addr & 16'hFFF0. dc_wdata is also captured for stores.
- Fill states (IC_FILL, DC_FILL):
  - Grant cycle is G, the first cycle in the state. Reads issue in cycles G..G+7, with mem_addr = base | (issue_cnt<<1) and mem_wr=0.
  - issue_cnt runs 0..8; mem_enable drops once it reaches 8.
  - Each memory_data_valid increments ret_cnt and pulses the owner's *_data_valid in the same cycle (combinational).
  - When ret_cnt reaches 8 (last valid at G+7+MEM_LAT), the state moves to IDLE at the next edge. Grant drops, last_owner is updated and both counters clear.
  - Total occupancy is 8+MEM_LAT cycles.
- DC_WRITE:
  - One cycle: mem_enable=1, mem_wr=1, mem_addr=dc_addr (full, unmasked), mem_wdata=captured data.
  - Returns to IDLE next edge. dc_grant is high for exactly 1 cycle.
- Grant and ownership:
  - Grant is held for the whole transaction. Requests dropped mid-transaction are ignored and the transaction completes.
  - A new grant is issued no earlier than the cycle after the return to IDLE; no back-to-back overlap.
  - ic_grant and dc_grant are never both high.
  - memory_data_valid outside a fill state is ignored.
- Reset mid-transaction: immediate return to IDLE with counters cleared. The requester must re-request.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - Adds two 16-bit saturating outputs, ic_wait_cycles and dc_wait_cycles.
  - Each increments every cycle its *_wait is high, holds at 16'hFFFF, and clears on rst.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding (2-bit): IDLE=0, IC_FILL=1, DC_FILL=2, DC_WRITE=3;
  - owner encoding: IC=0, DC=1;
  - BLOCK_MASK = 16'hFFF0;
  - BLOCK_WORDS.
- One natural sub-module, arb_burst_ctr: a 4-bit counter with clear and increment enable and a done flag at BLOCK_WORDS. It is instantiated twice, for issue and return counts.

Test Plan:
- ic_req=1, ic_addr=16'h1234, MEM_LAT=4 -> ic_grant from the next cycle; mem_addr 16'h1230,32,...,3E over 8 cycles; 8 ic_data_valid pulses; grant drops after 12 cycles.
- ic_req and dc_req (dc_we=0, dc_addr=16'h0400) both raised right after reset -> D-cache filled first (16'h0400-040E) with ic_wait high throughout; I-cache granted afterwards.
- Two consecutive simultaneous-request rounds -> grants alternate DC, IC, DC, IC.
- dc_req=1, dc_we=1, dc_addr=16'h0A06, dc_wdata=16'hBEEF -> one cycle of mem_enable=1, mem_wr=1, mem_addr=16'h0A06, mem_wdata=16'hBEEF; dc_grant high for 1 cycle.
- rst asserted after 3 ic reads issued -> all outputs 0 asynchronously; later memory_data_valid produces no *_data_valid.
- With ARB_PERF_CNT_EN, dc_req held during a 12-cycle I-cache fill -> dc_wait_cycles = 12.
